// File: rtl/udp_tx_arbiter.sv
// Two-input round-robin packet arbiter for the UDP transmit path.
// Grants whole packets, drops stalled or empty ones, and keeps per-port counters.
module udp_tx_arbiter #(
    parameter int DATA_W  = 7680,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_data,
    input  logic [15:0]       s0_length,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic [15:0]       s1_length,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [15:0]       m_length,
    output logic [1:0]        grant,
    output logic [15:0]       sent_cnt0,
    output logic [15:0]       sent_cnt1,
    output logic [15:0]       drop_cnt0,
    output logic [15:0]       drop_cnt1
);

    typedef enum logic [1:0] {IDLE, SEND, REJECT, DONE} state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            last_port;
    logic            sel;
    logic [15:0]     sel_len;
    logic            any_valid;
    logic            wd_expire;
    logic            take;
    logic            sent_inc;
    logic            drop_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // With both ports pending, the port not served last wins.
    always_comb begin
        any_valid = s0_valid | s1_valid;
        sel       = (s0_valid & s1_valid) ? ~last_port : s1_valid;
        sel_len   = sel ? s1_length : s0_length;
    end

    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        sent_inc  = 1'b0;
        drop_inc  = 1'b0;
        m_valid   = 1'b0;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    take      = 1'b1;
                    state_nxt = (sel_len == 16'd0) ? REJECT : SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    sent_inc  = 1'b1;
                    state_nxt = DONE;
                end else if (wd_expire) begin
                    drop_inc  = 1'b1;
                    state_nxt = DONE;
                end
            end
            REJECT: begin
                drop_inc  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                s0_ready  = grant[0];
                s1_ready  = grant[1];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data    <= '0;
            m_length  <= '0;
            grant     <= '0;
            last_port <= 1'b1;
            wd_cnt    <= '0;
        end else begin
            if (take) begin
                m_data    <= sel ? s1_data : s0_data;
                m_length  <= sel_len;
                grant     <= sel ? 2'b10 : 2'b01;
                last_port <= sel;
                wd_cnt    <= '0;
            end
            if (state == SEND && !m_ready && !wd_expire)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == DONE)
                grant <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sent_cnt0 <= '0;
            sent_cnt1 <= '0;
            drop_cnt0 <= '0;
            drop_cnt1 <= '0;
        end else begin
            if (sent_inc && grant[0]) sent_cnt0 <= sat_inc(sent_cnt0);
            if (sent_inc && grant[1]) sent_cnt1 <= sat_inc(sent_cnt1);
            if (drop_inc && grant[0]) drop_cnt0 <= sat_inc(drop_cnt0);
            if (drop_inc && grant[1]) drop_cnt1 <= sat_inc(drop_cnt1);
        end
    end

endmodule
